// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/STALL/HALT control, PC-relative and register
// branches on registered flags. Define PC_SEQ_BRCNT_EN to add a saturating taken-branch counter.
module pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt_in,
  input  logic        br_valid,
  input  logic        br_reg,
  input  logic [2:0]  cond,
  input  logic [8:0]  imm,
  input  logic [15:0] reg_target,
  input  logic [2:0]  flag_we,
  input  logic [2:0]  flag_in,
  output logic [15:0] pc_out,
  output logic [2:0]  flags_out,
  output logic        halted,
  output logic        taken,
  output logic [15:0] br_cnt
);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  flags_q, flags_d;
  logic        taken_q, taken_d;
  logic        halted_q, halted_d;

  logic        active;
  logic        cond_true;
  logic [15:0] seq_pc;
  logic [15:0] b_target;
  logic [15:0] target;

  // Flag positions within flags_q.
  logic flag_n, flag_z, flag_v;
  assign flag_n = flags_q[0];
  assign flag_z = flags_q[1];
  assign flag_v = flags_q[2];

  assign seq_pc   = pc_q + 16'd2;
  assign b_target = seq_pc + {{6{imm[8]}}, imm, 1'b0};
  assign target   = br_reg ? reg_target : b_target;
  assign active   = (state_q != HALT) && !stall && !halt_in;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000: cond_true = !flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = !flag_z && !flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z || (!flag_z && !flag_n);
      3'b101: cond_true = flag_n || flag_z;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    taken_d = 1'b0;

    case (state_q)
      RUN, STALL: begin
        if (stall)        state_d = STALL;
        else if (halt_in) state_d = HALT;
        else              state_d = RUN;
      end
      default: state_d = HALT;
    endcase

    // Flags written this cycle only become visible to conditions next cycle.
    if (active) begin
      flags_d = (flags_q & ~flag_we) | (flag_in & flag_we);
      if (br_valid && cond_true) begin
        pc_d    = target;
        taken_d = 1'b1;
      end else begin
        pc_d = seq_pc;
      end
    end

    halted_d = (state_d == HALT);
  end

`ifdef PC_SEQ_BRCNT_EN
  logic [15:0] br_cnt_q, br_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    if (taken_d && (br_cnt_q != 16'hFFFF)) br_cnt_d = br_cnt_q + 16'd1;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= 16'h0000;
      flags_q  <= 3'b000;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
`ifdef PC_SEQ_BRCNT_EN
      br_cnt_q <= 16'h0000;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      taken_q  <= taken_d;
      halted_q <= halted_d;
`ifdef PC_SEQ_BRCNT_EN
      br_cnt_q <= br_cnt_d;
`endif
    end
  end

  assign pc_out    = pc_q;
  assign flags_out = flags_q;
  assign taken     = taken_q;
  assign halted    = halted_q;

`ifdef PC_SEQ_BRCNT_EN
  assign br_cnt = br_cnt_q;
`else
  assign br_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push hand-computed
// post-edge expectations; a monitor pops and compares them after each clock edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, halt_in, br_valid, br_reg;
  logic [2:0]  cond;
  logic [8:0]  imm;
  logic [15:0] reg_target;
  logic [2:0]  flag_we, flag_in;
  logic [15:0] pc_out;
  logic [2:0]  flags_out;
  logic        halted, taken;
  logic [15:0] br_cnt;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_in(halt_in),
    .br_valid(br_valid), .br_reg(br_reg), .cond(cond), .imm(imm),
    .reg_target(reg_target), .flag_we(flag_we), .flag_in(flag_in),
    .pc_out(pc_out), .flags_out(flags_out), .halted(halted),
    .taken(taken), .br_cnt(br_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] pc;
    logic [2:0]  flags;
    logic        halted;
    logic        taken;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

`ifdef PC_SEQ_BRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic check(input string name, input int id, input logic [15:0] act,
                       input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, id, act, req);
    end
  endtask

  // Monitor: the design presents a new output set after every edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc_out",    e.id, pc_out,             e.pc);
      check("flags_out", e.id, {13'd0, flags_out}, {13'd0, e.flags});
      check("halted",    e.id, {15'd0, halted},    {15'd0, e.halted});
      check("taken",     e.id, {15'd0, taken},     {15'd0, e.taken});
      check("br_cnt",    e.id, br_cnt,             e.cnt);
    end
  end

  int vec = 0;

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  // n_taken is the taken-branch count since reset; br_cnt only tracks it when enabled.
  task automatic step(input logic r, input logic s, input logic h, input logic bv,
                      input logic brg, input logic [2:0] c, input logic [8:0] im,
                      input logic [15:0] rt, input logic [2:0] we, input logic [2:0] fi,
                      input logic [15:0] e_pc, input logic [2:0] e_fl, input logic e_h,
                      input logic e_t, input logic [15:0] n_taken);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; halt_in = h; br_valid = bv; br_reg = brg;
    cond = c; imm = im; reg_target = rt; flag_we = we; flag_in = fi;
    e.id = vec; e.pc = e_pc; e.flags = e_fl; e.halted = e_h; e.taken = e_t;
    e.cnt = CNT_EN ? n_taken : 16'h0000;
    exp_q.push_back(e);
    vec++;
  endtask

  initial begin
    rst = 1'b1; stall = 0; halt_in = 0; br_valid = 0; br_reg = 0;
    cond = 0; imm = 0; reg_target = 0; flag_we = 0; flag_in = 0;

    //    rst s h bv brg cond    imm     reg_tgt   we      fi      pc        flags   h t  n
    step(1, 0,0,0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0000, 3'b000, 0,0, 0);
    step(1, 1,1,1, 0, 3'b111, 9'h010, 16'h0000, 3'b111, 3'b111, 16'h0000, 3'b000, 0,0, 0);
    // Three idle cycles count up by two.
    step(0, 0,0,0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0002, 3'b000, 0,0, 0);
    step(0, 0,0,0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0004, 3'b000, 0,0, 0);
    step(0, 0,0,0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0006, 3'b000, 0,0, 0);
    // BR to 0x0010 while setting Z.
    step(0, 0,0,1, 1, 3'b111, 9'h000, 16'h0010, 3'b010, 3'b010, 16'h0010, 3'b010, 0,1, 1);
    // B Z, imm=-2: 0x0012 - 4 = 0x000E; then taken drops.
    step(0, 0,0,1, 0, 3'b001, 9'h1FE, 16'h0000, 3'b000, 3'b000, 16'h000E, 3'b010, 0,1, 2);
    step(0, 0,0,0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0010, 3'b010, 0,0, 2);
    // Clear Z, then branch on Z while writing Z=1: uses the old flag.
    step(0, 0,0,0, 0, 3'b000, 9'h000, 16'h0000, 3'b010, 3'b000, 16'h0012, 3'b000, 0,0, 2);
    step(0, 0,0,1, 0, 3'b001, 9'h005, 16'h0000, 3'b010, 3'b010, 16'h0014, 3'b000 | 3'b010, 0,0, 2);
    step(0, 0,0,1, 0, 3'b001, 9'h005, 16'h0000, 3'b000, 3'b000, 16'h0020, 3'b010, 0,1, 3);
    // Stall three cycles with a pending always-branch; halt and flag writes ignored.
    step(0, 1,0,1, 0, 3'b111, 9'h003, 16'h0000, 3'b111, 3'b111, 16'h0020, 3'b010, 0,0, 3);
    step(0, 1,1,1, 0, 3'b111, 9'h003, 16'h0000, 3'b000, 3'b000, 16'h0020, 3'b010, 0,0, 3);
    step(0, 1,0,1, 0, 3'b111, 9'h003, 16'h0000, 3'b000, 3'b000, 16'h0020, 3'b010, 0,0, 3);
    step(0, 0,0,1, 0, 3'b111, 9'h003, 16'h0000, 3'b000, 3'b000, 16'h0028, 3'b010, 0,1, 4);
    // Condition codes with flags {V,Z,N}=010.
    step(0, 0,0,1, 0, 3'b000, 9'h007, 16'h0000, 3'b000, 3'b000, 16'h002A, 3'b010, 0,0, 4);
    step(0, 0,0,1, 0, 3'b100, 9'h003, 16'h0000, 3'b111, 3'b101, 16'h0032, 3'b101, 0,1, 5);
    // Flags now V=1, Z=0, N=1.
    step(0, 0,0,1, 0, 3'b010, 9'h003, 16'h0000, 3'b000, 3'b000, 16'h0034, 3'b101, 0,0, 5);
    step(0, 0,0,1, 0, 3'b110, 9'h1FF, 16'h0000, 3'b000, 3'b000, 16'h0034, 3'b101, 0,1, 6);
    step(0, 0,0,1, 1, 3'b011, 9'h000, 16'hFFFE, 3'b000, 3'b000, 16'hFFFE, 3'b101, 0,1, 7);
    // Wrap from 0xFFFE to 0x0000.
    step(0, 0,0,0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0000, 3'b101, 0,0, 7);
    step(0, 0,0,1, 1, 3'b101, 9'h000, 16'h0030, 3'b000, 3'b000, 16'h0030, 3'b101, 0,1, 8);
    // HLT beats an always-branch; HALT holds through branches and stalls.
    step(0, 0,1,1, 1, 3'b111, 9'h000, 16'h1234, 3'b111, 3'b000, 16'h0030, 3'b101, 1,0, 8);
    step(0, 0,0,1, 1, 3'b111, 9'h000, 16'h1234, 3'b111, 3'b000, 16'h0030, 3'b101, 1,0, 8);
    step(0, 1,0,0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0030, 3'b101, 1,0, 8);
    step(1, 1,1,1, 1, 3'b111, 9'h000, 16'h1234, 3'b000, 3'b000, 16'h0000, 3'b000, 0,0, 0);
    step(0, 0,0,0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0002, 3'b000, 0,0, 0);
    // HLT taken from the STALL state.
    step(0, 1,0,0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0002, 3'b000, 0,0, 0);
    step(0, 0,1,0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0002, 3'b000, 1,0, 0);
    step(1, 0,0,0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0000, 3'b000, 0,0, 0);
    step(0, 0,0,1, 1, 3'b111, 9'h000, 16'h0040, 3'b000, 3'b000, 16'h0040, 3'b000, 0,1, 1);

    @(negedge clk);
    rst = 1'b0; br_valid = 1'b0; halt_in = 1'b0; stall = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports SHALL be:
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 stall  input  1  hold PC and flags this cycle (memory or hazard stall).
REQ-005 halt_in  input  1  decoded HLT in current instruction.
REQ-006 br_valid  input  1  current instruction is a branch.
REQ-007 br_reg  input  1  1 = register branch (BR), 0 = PC-relative branch (B).
REQ-008 cond  input  3  branch condition code.
REQ-009 imm  input  9  signed word offset for B.
REQ-010 reg_target  input  16  target address for BR.
REQ-011 flag_we  input  3  per-flag write enable {V,Z,N} = bits [2:0] as {2,1,0}.
REQ-012 flag_in  input  3  new flag values, N=[0], Z=[1], V=[2].
REQ-013 pc_out  output  16  current fetch address (registered).
REQ-014 flags_out  output  3  registered flags, same bit order as flag_in.
REQ-015 halted  output  1  high while in HALT state.
REQ-016 taken  output  1  registered one-cycle pulse: a branch was taken last cycle.
REQ-017 br_cnt  output  16  taken-branch count (see Configuration).

Function
REQ-018 States SHALL be RUN, STALL, HALT; state SHALL be registered.
REQ-019 RUN: stall=1 -> STALL; else halt_in=1 -> HALT; else remain RUN.
REQ-020 STALL: stall=0 -> RUN; stall=1 -> remain STALL; halt_in and br_valid SHALL be ignored while stall=1.
REQ-021 HALT SHALL be exited only by rst.
REQ-022 Active cycle = state RUN or STALL, stall=0, no halt_in; only active cycles SHALL update pc_out, flags_out, taken, br_cnt.
REQ-023 seq = pc_out + 2, modulo 2^16.
REQ-024 B target = seq + (sign-extended imm << 1), 16-bit, modulo 2^16, no overflow detection.
REQ-025 BR target = reg_target unchanged.
REQ-026 Conditions SHALL be evaluated on flags_out (registered), never on same-cycle flag_in: 000 !Z; 001 Z; 010 !Z&!N; 011 N; 100 Z|(!Z&!N); 101 N|Z; 110 V; 111 always.
REQ-027 Active cycle with br_valid=1 and condition true: pc_out <= target, taken <= 1; otherwise pc_out <= seq, taken <= 0.
REQ-028 Active cycle: each flag bit i SHALL load flag_in[i] iff flag_we[i]=1; other bits hold.
REQ-029 halt_in with stall=0 (RUN or STALL state): pc_out SHALL hold the HLT address, flags hold, taken <= 0, enter HALT; halt_in beats simultaneous br_valid.
REQ-030 Stall cycles and HALT: pc_out, flags_out hold; taken <= 0.
REQ-031 halted SHALL equal (state == HALT), registered, latency one cycle after the halt_in cycle.
REQ-032 pc_out wrap: 0xFFFE + 2 -> 0x0000 with no other effect.

Reset
REQ-033 On rst=1 at a clock edge: pc_out=0x0000, flags_out=3'b000, state=RUN, halted=0, taken=0, br_cnt=0x0000.
REQ-034 rst SHALL override stall, halt_in, br_valid and any state, including HALT and mid-stall.

Configuration
REQ-035 Macro PC_SEQ_BRCNT_EN: when defined, br_cnt SHALL increment by 1 on every cycle that sets taken, saturating at 0xFFFF.
REQ-036 When PC_SEQ_BRCNT_EN is undefined, br_cnt SHALL be constant 0x0000 and no counter register SHALL exist; all other behaviour identical.

Verification
REQ-037 Reset then 3 idle cycles -> pc_out 0x0000, 0x0002, 0x0004, 0x0006; taken=0.
REQ-038 pc_out=0x0010, flags Z=1, br_valid=1, br_reg=0, cond=001, imm=9'h1FE (-2) -> next pc_out=0x000E, taken=1 for one cycle.
REQ-039 Same cycle flag_we=3'b010, flag_in Z=1, with old Z=0, cond=001 branch -> not taken (uses old flag), pc_out=seq; next cycle flags_out Z=1.
REQ-040 pc_out=0x0020, stall=1 for 3 cycles with br_valid=1, cond=111 -> pc_out holds 0x0020, taken=0; stall drop -> branch taken.
REQ-041 halt_in=1 and br_valid=1, cond=111 at pc_out=0x0030 -> pc_out holds 0x0030, halted=1 next cycle, stays until rst; rst -> pc_out=0x0000, halted=0.
REQ-042 With PC_SEQ_BRCNT_EN: 5 taken branches, 2 untaken -> br_cnt=5; without macro -> br_cnt=0.
